// File: rtl/multi_req_detect_sched.sv
// Round-robin scheduler that serialises one of four requesters' frames LSB-first
// into a shared external Mealy "101" detector and counts its hits per frame.
module multi_req_detect_sched #(
  parameter int FRAME_W = 8,
  parameter int CNT_W   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             req,
  input  logic [4*FRAME_W-1:0]   frame_data,
  output logic [3:0]             gnt,
  output logic [3:0]             done,
  output logic [CNT_W-1:0]       match_cnt,
  output logic                   busy,
  output logic                   det_x,
  input  logic                   det_y
);

  localparam int SC_W = $clog2(FRAME_W);
  localparam logic [SC_W-1:0] SHIFT_LAST = SC_W'(FRAME_W - 1);

  typedef enum logic [1:0] {IDLE, FLUSH, SHIFT, DONE} state_t;

  state_t             state;
  logic [FRAME_W-1:0] sreg;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [SC_W-1:0]    bit_idx;
  logic               flush_idx;
  logic [1:0]         last_gnt;
  logic [1:0]         win_idx;
  logic               win_vld;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic hit);
    if (hit && (v != {CNT_W{1'b1}}))
      return v + 1'b1;
    return v;
  endfunction

  // Search starts just above the last winner and wraps modulo 4.
  always_comb begin
    win_vld = 1'b0;
    win_idx = last_gnt;
    for (int i = 1; i <= 4; i++) begin
      if (!win_vld && req[2'(last_gnt + 2'(i))]) begin
        win_vld = 1'b1;
        win_idx = 2'(last_gnt + 2'(i));
      end
    end
  end

  assign cnt_nxt = sat_inc(cnt, det_y);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      gnt       <= '0;
      done      <= '0;
      busy      <= 1'b0;
      det_x     <= 1'b0;
      match_cnt <= '0;
      cnt       <= '0;
      sreg      <= '0;
      bit_idx   <= '0;
      flush_idx <= 1'b0;
      last_gnt  <= 2'd3;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            gnt       <= 4'b0001 << win_idx;
            last_gnt  <= win_idx;
            sreg      <= frame_data[win_idx*FRAME_W +: FRAME_W];
            cnt       <= '0;
            flush_idx <= 1'b0;
            busy      <= 1'b1;
            state     <= FLUSH;
          end
        end
        // Two zeros drive the detector back to its start state whatever it held.
        FLUSH: begin
          flush_idx <= 1'b1;
          if (flush_idx) begin
            bit_idx <= '0;
            det_x   <= sreg[0];
            state   <= SHIFT;
          end
        end
        // det_x always mirrors sreg[0]; det_y answers for the bit on the wire now.
        SHIFT: begin
          sreg    <= sreg >> 1;
          cnt     <= cnt_nxt;
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == SHIFT_LAST) begin
            det_x     <= 1'b0;
            done      <= gnt;
            match_cnt <= cnt_nxt;
            state     <= DONE;
          end else begin
            det_x <= sreg[1];
          end
        end
        DONE: begin
          gnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_req_detect_sched.sv
// Bench for multi_req_detect_sched: behavioural 101 detectors, vector table,
// scoreboard of expected completions, plus reset and back-to-back sequences.
module tb_multi_req_detect_sched;

  localparam int FW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    req;
  logic [4*FW-1:0] frame_data;
  logic [3:0]    gnt, done, gnt1, done1;
  logic [3:0]    match_cnt;
  logic [0:0]    match_cnt1;
  logic          busy, busy1, det_x, det_x1, det_y, det_y1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Independent Mealy 101 detectors (overlapping), never reset by the DUT reset.
  logic [1:0] ds = 2'd0, ds1 = 2'd0;

  function automatic logic [1:0] det_next(input logic [1:0] s, input logic x);
    case (s)
      2'd0:    return x ? 2'd1 : 2'd0;
      2'd1:    return x ? 2'd1 : 2'd2;
      2'd2:    return x ? 2'd1 : 2'd0;
      default: return 2'd0;
    endcase
  endfunction

  assign det_y  = (ds  == 2'd2) && det_x;
  assign det_y1 = (ds1 == 2'd2) && det_x1;
  always @(posedge clk) begin
    ds  <= det_next(ds, det_x);
    ds1 <= det_next(ds1, det_x1);
  end

  multi_req_detect_sched #(.FRAME_W(FW), .CNT_W(4)) u_dut (
    .clk(clk), .reset(reset), .req(req), .frame_data(frame_data),
    .gnt(gnt), .done(done), .match_cnt(match_cnt), .busy(busy),
    .det_x(det_x), .det_y(det_y)
  );

  multi_req_detect_sched #(.FRAME_W(FW), .CNT_W(1)) u_sat (
    .clk(clk), .reset(reset), .req(req), .frame_data(frame_data),
    .gnt(gnt1), .done(done1), .match_cnt(match_cnt1), .busy(busy1),
    .det_x(det_x1), .det_y(det_y1)
  );

  typedef struct {
    int idx;
    int cnt;
    int cnt1;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [3:0]  r;
    logic [31:0] fd;
    int          idx;
    int          cnt;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Waits for a grant, follows the frame through to its done pulse.
  task automatic serve_one(input int idx, input int cnt, input bit cont, output int done_cyc);
    int g, rel, xerr, gerr;
    bit got;
    logic [7:0] fr;
    logic exp_x;
    exp_t e;
    got = 0;
    done_cyc = -1;
    for (int k = 0; k < 16 && !got; k++) begin
      @(negedge clk);
      if (gnt != 4'b0) got = 1;
    end
    if (!got) begin
      chk("grant_timeout", 32'd0, 32'd1);
      return;
    end
    g = cyc;
    chk("gnt", gnt, 4'b0001 << idx);
    chk("gnt_sat", gnt1, 4'b0001 << idx);
    chk("busy", busy, 1);
    fr = frame_data[idx*FW +: FW];
    sb.push_back('{idx, cnt, (cnt > 1) ? 1 : cnt});
    if (!cont) req = 4'b0;
    xerr = 0;
    gerr = 0;
    got  = 0;
    rel  = 1;
    while (!got && rel <= FW + 6) begin
      exp_x = (rel >= 3 && rel <= FW + 2) ? fr[rel-3] : 1'b0;
      if (det_x !== exp_x) xerr++;
      if (gnt !== (4'b0001 << idx)) gerr++;
      if (done != 4'b0) got = 1;
      else begin
        if (!cont && rel == 4) begin
          req = 4'($urandom);
          frame_data = $urandom;
        end
        if (!cont && rel == 8) req = 4'b0;
        @(negedge clk);
        rel = cyc - g + 1;
      end
    end
    chk("det_x_seq", xerr, 0);
    chk("gnt_hold", gerr, 0);
    if (!got) begin
      chk("done_timeout", 32'd0, 32'd1);
      return;
    end
    chk("latency", rel, FW + 3);
    done_cyc = cyc;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk("done", done, 4'b0001 << e.idx);
    chk("done_sat", done1, 4'b0001 << e.idx);
    chk("match_cnt", match_cnt, e.cnt);
    chk("match_cnt_sat", match_cnt1, e.cnt1);
    if (!cont) begin
      @(negedge clk);
      chk("idle_gnt", gnt, 0);
      chk("idle_done", done, 0);
      chk("idle_busy", busy, 0);
    end
  endtask

  initial begin
    int dc, prev, bad;
    int ord[5];
    int ocnt[5];
    vecs[0] = '{4'b0001, 32'hFFFFFF15, 0, 2};
    vecs[1] = '{4'b0001, 32'hFFFFFF55, 0, 3};
    vecs[2] = '{4'b0001, 32'hFFFFFF05, 0, 1};
    vecs[3] = '{4'b0001, 32'h000000FF, 0, 0};
    vecs[4] = '{4'b0001, 32'hFFFFFF00, 0, 0};
    vecs[5] = '{4'b1001, 32'h55FFFF15, 3, 3};
    vecs[6] = '{4'b1001, 32'h55FFFF2D, 0, 2};
    vecs[7] = '{4'b0110, 32'hFF05AAFF, 1, 3};
    vecs[8] = '{4'b0110, 32'hFF05AAFF, 2, 1};
    ord  = '{0, 1, 2, 3, 0};
    ocnt = '{2, 3, 1, 3, 2};

    reset = 1'b1;
    req = 4'b0;
    frame_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_det_x", det_x, 0);
    chk("rst_match_cnt", match_cnt, 0);
    chk("rst_busy_sat", busy1, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 9; v++) begin
      @(negedge clk);
      req = vecs[v].r;
      frame_data = vecs[v].fd;
      serve_one(vecs[v].idx, vecs[v].cnt, 1'b0, dc);
    end

    // Reset in the middle of SHIFT with the detector left in its "10" state.
    @(negedge clk);
    req = 4'b0001;
    frame_data = 32'hFFFFFF55;
    @(negedge clk);
    chk("mid_gnt", gnt, 4'b0001);
    req = 4'b0;
    repeat (6) @(negedge clk);
    chk("mid_det_state", ds, 2'd2);
    #2 reset = 1'b1;
    #1;
    chk("async_gnt", gnt, 0);
    chk("async_busy", busy, 0);
    chk("async_det_x", det_x, 0);
    chk("async_done", done, 0);
    chk("async_match_cnt", match_cnt, 0);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (14) begin
      @(negedge clk);
      if (done != 4'b0 || gnt != 4'b0) bad++;
    end
    chk("no_done_after_reset", bad, 0);
    @(negedge clk);
    req = 4'b0001;
    frame_data = 32'h00000015;
    serve_one(0, 2, 1'b0, dc);

    // Re-arm priority at requester 0, then all four request continuously.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    req = 4'b1111;
    frame_data = {8'hAA, 8'h05, 8'h55, 8'h15};
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      serve_one(ord[k], ocnt[k], 1'b1, dc);
      if (k > 0) chk("period", dc - prev, FW + 4);
      prev = dc;
    end
    req = 4'b0;
    repeat (16) @(negedge clk);
    chk("idle_end", busy, 0);
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
